// File: rtl/spi_pkg.sv
// Shared definitions for the serial-link blocks (spi_tx / spi_rx family).
package spi_pkg;

  // Default word length on the serial link.
  localparam int SPI_WIDTH = 8;

  // Receiver state: waiting for a frame, or shifting bits in.
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } spi_rx_state_t;

endpackage

// File: rtl/spi_rx_if.sv
// Serial-in / parallel-out bundle between a bit-stream sender and spi_rx.
//
// Handshake: there is no back-pressure. While frame is high the sender
// presents one new sbit per rising clk edge; the receiver samples on that
// edge. done is a one-cycle pulse meaning data was just updated; data is
// held until the next done. abort is sticky until the next frame starts.
// sbit carries the serial bit ("bit" itself is a reserved word).
interface spi_rx_if
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) ();

  logic             sbit;
  logic             frame;
  logic [WIDTH-1:0] data;
  logic             done;
  logic             abort;
  logic             busy;
  spi_rx_state_t    state;   // debug view of the receiver FSM

  // Sender/consumer side.
  modport master (
    output sbit, frame,
    input  data, done, abort, busy, state
  );

  // Receiver side.
  modport slave (
    input  sbit, frame,
    output data, done, abort, busy, state
  );

endinterface

// File: rtl/spi_rx_shifter.sv
// Shift register plus bit counter for spi_rx. Shifts MSB-first on load,
// wraps the counter to zero when a word completes, and drops any partial
// word on clear.
module spi_rx_shifter #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             clear,
  input  logic             sbit,
  output logic [CW-1:0]    count,
  output logic [WIDTH-1:0] next_word,
  output logic             full
);

  logic [WIDTH-1:0] shreg;

  // Word as it will look once the current bit is shifted in.
  assign next_word = {shreg[WIDTH-2:0], sbit};

  // This edge delivers the last bit of a word.
  assign full = load && (count == CW'(WIDTH - 1));

  // Shift register and counter; counter never exceeds WIDTH-1 at rest.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shreg <= '0;
      count <= '0;
    end else if (clear) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= next_word;
      count <= full ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/spi_rx.sv
// Serial-to-parallel receiver: assembles MSB-first bits sampled while frame
// is high into WIDTH-bit words, pulses done per word, flags short frames.
module spi_rx
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic      clk,
  input  logic      rst_n,
  spi_rx_if.slave   bus
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    count;
  logic [WIDTH-1:0] next_word;
  logic             full;
  logic [WIDTH-1:0] data_q;
  logic             done_q;
  logic             abort_q;
  spi_rx_state_t    state;

  // Bits are taken whenever frame is high; a low frame drops any partial word.
  spi_rx_shifter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_shifter (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (bus.frame),
    .clear     (!bus.frame),
    .sbit      (bus.sbit),
    .count     (count),
    .next_word (next_word),
    .full      (full)
  );

  assign bus.data  = data_q;
  assign bus.done  = done_q;
  assign bus.abort = abort_q;
  assign bus.busy  = (count != '0);
  assign bus.state = state;

  // Frame-tracking FSM with registered data/done/abort.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      data_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frame) begin
            state   <= SHIFT;
            abort_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (bus.frame) begin
            if (full) begin
              data_q <= next_word;
              done_q <= 1'b1;
            end
          end else begin
            state <= IDLE;
            if (count != '0) abort_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_rx.sv
// Bench for spi_rx: scenario tasks with inline checks plus a scoreboard of
// expected words popped whenever done is seen.
module tb_spi_rx;
  import spi_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spi_rx_if #(.WIDTH(W)) bus ();

  spi_rx #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks;
  int errors;
  int done_cnt;

  // One clock: sample outputs at negedge (scoreboard), advance past posedge.
  task automatic tick();
    logic [W-1:0] exp;
    @(negedge clk);
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_done: data=%h required no done", bus.data);
      end else begin
        exp = exp_q.pop_front();
        if (bus.data !== exp) begin
          errors++;
          $display("FAIL sb_data: data=%h required %h", bus.data, exp);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- drivers ----------------
  // Present the top n bits of w, MSB first, one per edge with frame high.
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      bus.sbit  = w[W-1-i];
      bus.frame = 1'b1;
      tick();
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame = 1'b0;
      bus.sbit  = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    bus.frame = 1'b0;
    bus.sbit  = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.data !== 8'h00 || bus.done !== 1'b0 || bus.abort !== 1'b0 ||
        bus.busy !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset: data=%h done=%b abort=%b busy=%b state=%0d required 00 0 0 0 0",
               bus.data, bus.done, bus.abort, bus.busy, bus.state);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    exp_q.push_back(8'h35);
    send_bits(8'h35, W);
    checks++;
    if (bus.done !== 1'b1 || bus.data !== 8'h35 || bus.abort !== 1'b0) begin
      errors++;
      $display("FAIL single_word: done=%b data=%h abort=%b required 1 35 0",
               bus.done, bus.data, bus.abort);
    end
    idle(1);
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.data !== 8'h35) begin
      errors++;
      $display("FAIL single_done_width: done=%b busy=%b data=%h required 0 0 35",
               bus.done, bus.busy, bus.data);
    end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'h35);
    exp_q.push_back(8'hCC);
    send_bits(8'h35, W);
    checks++;
    if (bus.done !== 1'b1 || bus.data !== 8'h35) begin
      errors++;
      $display("FAIL b2b_first: done=%b data=%h required 1 35", bus.done, bus.data);
    end
    send_bits(8'hCC, 1);
    checks++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.state !== SHIFT) begin
      errors++;
      $display("FAIL b2b_second_start: busy=%b done=%b state=%0d required 1 0 1",
               bus.busy, bus.done, bus.state);
    end
    send_bits(8'hCC << 1, W - 1);
    checks++;
    if (bus.done !== 1'b1 || bus.data !== 8'hCC || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second: done=%b data=%h busy=%b required 1 cc 0",
               bus.done, bus.data, bus.busy);
    end
    idle(1);
    checks++;
    if (done_cnt - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_pulses: got %0d required 2", done_cnt - d0);
    end
  endtask

  task automatic test_abort();
    exp_q.push_back(8'hCC);
    send_bits(8'hCC, W);
    send_bits(8'b1100_0000, 3);
    idle(1);
    checks++;
    if (bus.abort !== 1'b1 || bus.data !== 8'hCC || bus.done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL abort_set: abort=%b data=%h done=%b busy=%b state=%0d required 1 cc 0 0 0",
               bus.abort, bus.data, bus.done, bus.busy, bus.state);
    end
    idle(2);
    checks++;
    if (bus.abort !== 1'b1) begin
      errors++;
      $display("FAIL abort_sticky: abort=%b required 1", bus.abort);
    end
    exp_q.push_back(8'h29);
    send_bits(8'h29, 1);
    checks++;
    if (bus.abort !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_clear: abort=%b busy=%b required 0 1", bus.abort, bus.busy);
    end
    send_bits(8'h29 << 1, W - 1);
    checks++;
    if (bus.data !== 8'h29 || bus.done !== 1'b1 || bus.abort !== 1'b0) begin
      errors++;
      $display("FAIL abort_next_word: data=%h done=%b abort=%b required 29 1 0",
               bus.data, bus.done, bus.abort);
    end
    idle(1);
  endtask

  task automatic test_reset_mid_word();
    send_bits(8'hF0, 5);
    rst_n     = 1'b0;
    bus.frame = 1'b0;
    tick();
    checks++;
    if (bus.data !== 8'h00 || bus.busy !== 1'b0 || bus.abort !== 1'b0 ||
        bus.done !== 1'b0 || bus.state !== IDLE) begin
      errors++;
      $display("FAIL reset_mid: data=%h busy=%b abort=%b done=%b state=%0d required 00 0 0 0 0",
               bus.data, bus.busy, bus.abort, bus.done, bus.state);
    end
    rst_n = 1'b1;
    exp_q.push_back(8'hA5);
    send_bits(8'hA5, W);
    checks++;
    if (bus.data !== 8'hA5 || bus.done !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_recover: data=%h done=%b required a5 1", bus.data, bus.done);
    end
    idle(1);
  endtask

  task automatic test_idle_noise();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 10; i++) begin
      bus.frame = 1'b0;
      bus.sbit  = i[0];
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.data !== 8'hA5 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL idle_noise[%0d]: busy=%b data=%h done=%b required 0 a5 0",
                 i, bus.busy, bus.data, bus.done);
      end
    end
    checks++;
    if (done_cnt !== d0) begin
      errors++;
      $display("FAIL idle_pulses: got %0d required 0", done_cnt - d0);
    end
  endtask

  task automatic test_gap();
    int d0;
    d0 = done_cnt;
    exp_q.push_back(8'h35);
    send_bits(8'h35, W);
    idle(1);
    exp_q.push_back(8'hCC);
    send_bits(8'hCC, W);
    idle(1);
    checks++;
    if (bus.abort !== 1'b0 || done_cnt - d0 !== 2 || bus.data !== 8'hCC) begin
      errors++;
      $display("FAIL gap: abort=%b pulses=%0d data=%h required 0 2 cc",
               bus.abort, done_cnt - d0, bus.data);
    end
  endtask

  task automatic test_random_stream();
    logic [W-1:0] w;
    for (int k = 0; k < 6; k++) begin
      w = W'($urandom_range(0, 255));
      exp_q.push_back(w);
      send_bits(w, W);
    end
    idle(2);
    checks++;
    if (bus.abort !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL random_stream: abort=%b busy=%b required 0 0", bus.abort, bus.busy);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks   = 0;
    errors   = 0;
    done_cnt = 0;
    rst_n     = 1'b0;
    bus.frame = 1'b0;
    bus.sbit  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid_word();
    test_idle_noise();
    test_gap();
    test_random_stream();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover: %0d expected words never produced, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
